// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception type codes,
// Status/Cause field positions and MTC0 write masks.
package cp0_regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // CP0 register numbers
  localparam logic [REG_AW-1:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [REG_AW-1:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [REG_AW-1:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [REG_AW-1:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [REG_AW-1:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [REG_AW-1:0] CP0_REG_EPC      = 5'd14;
  localparam logic [REG_AW-1:0] CP0_REG_PRID     = 5'd15;
  localparam logic [REG_AW-1:0] CP0_REG_CONFIG   = 5'd16;

  // Exception type codes presented by the exception decoder
  localparam logic [XLEN-1:0] EXC_INT  = 32'h0000_0001;
  localparam logic [XLEN-1:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [XLEN-1:0] EXC_ADES = 32'h0000_0005;
  localparam logic [XLEN-1:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [XLEN-1:0] EXC_BP   = 32'h0000_0009;
  localparam logic [XLEN-1:0] EXC_RI   = 32'h0000_000a;
  localparam logic [XLEN-1:0] EXC_OV   = 32'h0000_000c;
  localparam logic [XLEN-1:0] EXC_ERET = 32'h0000_000e;

  // Field positions
  localparam int unsigned STATUS_IE_BIT   = 0;
  localparam int unsigned STATUS_EXL_BIT  = 1;
  localparam int unsigned CAUSE_EXC_LSB   = 2;
  localparam int unsigned CAUSE_EXC_MSB   = 6;
  localparam int unsigned CAUSE_IP_HW_LSB = 10;
  localparam int unsigned CAUSE_IP_HW_MSB = 15;
  localparam int unsigned CAUSE_BD_BIT    = 31;

  // Reset values and MTC0 write masks
  localparam logic [XLEN-1:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [XLEN-1:0] CAUSE_WMASK  = 32'h0000_0300;

  // True for the exception types that enter an exception handler
  function automatic logic is_exception(input logic [XLEN-1:0] t);
    case (t)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Cause.ExcCode for an entering exception; the interrupt type maps to 0
  function automatic logic [4:0] exc_code(input logic [XLEN-1:0] t);
    if (t == EXC_INT) return 5'h00;
    return 5'(t);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, timer_int sets on
// Count==Compare (Compare nonzero) and clears on any Compare write.
// Ports: clk, resetn, count_we/compare_we + wdata (MTC0 write ports),
//        count, compare, timer_int (registered state).
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            count_we,
  input  logic            compare_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] count,
  output logic [XLEN-1:0] compare,
  output logic            timer_int
);

  logic            tick;
  logic            tick_nxt;
  logic [XLEN-1:0] count_nxt;
  logic [XLEN-1:0] compare_nxt;
  logic            timer_int_nxt;

  // Next-state: a Count write overrides the increment, a Compare write
  // clears the interrupt even if a match happens in the same cycle.
  always_comb begin
    tick_nxt      = ~tick;
    count_nxt     = count;
    compare_nxt   = compare;
    timer_int_nxt = timer_int;
    if (count_we) begin
      count_nxt = wdata;
    end else if (tick) begin
      count_nxt = count + XLEN'(1);
    end
    if (compare_we) begin
      compare_nxt   = wdata;
      timer_int_nxt = 1'b0;
    end else if ((count == compare) && (compare != '0)) begin
      timer_int_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick      <= 1'b0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      tick      <= tick_nxt;
      count     <= count_nxt;
      compare   <= compare_nxt;
      timer_int <= timer_int_nxt;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception-state controller.
// Ports: clk/resetn; MTC0 write (we_i, waddr_i, wdata_i); MFC0 read
// (raddr_i -> rdata_o, combinational); int_i hardware interrupts; exception
// commit (excepttype_i, pc_i, is_in_delayslot_i, bad_addr_i); registered
// register views (count_o .. badvaddr_o) and timer_int_o.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VALUE = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr_i,
  output logic [XLEN-1:0]   rdata_o,
  input  logic [5:0]        int_i,
  input  logic [XLEN-1:0]   excepttype_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              is_in_delayslot_i,
  input  logic [XLEN-1:0]   bad_addr_i,
  output logic [XLEN-1:0]   count_o,
  output logic [XLEN-1:0]   compare_o,
  output logic [XLEN-1:0]   status_o,
  output logic [XLEN-1:0]   cause_o,
  output logic [XLEN-1:0]   epc_o,
  output logic [XLEN-1:0]   badvaddr_o,
  output logic              timer_int_o
);

  logic [XLEN-1:0] status_nxt;
  logic [XLEN-1:0] cause_nxt;
  logic [XLEN-1:0] epc_nxt;
  logic [XLEN-1:0] badvaddr_nxt;

  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (we_i && (waddr_i == CP0_REG_COUNT)),
    .compare_we (we_i && (waddr_i == CP0_REG_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

  // Next-state: MTC0 first, then exception/ERET overrides the fields it owns.
  always_comb begin
    status_nxt   = status_o;
    cause_nxt    = cause_o;
    epc_nxt      = epc_o;
    badvaddr_nxt = badvaddr_o;

    cause_nxt[CAUSE_IP_HW_MSB:CAUSE_IP_HW_LSB] = {int_i[5] | timer_int_o, int_i[4:0]};

    if (we_i) begin
      case (waddr_i)
        CP0_REG_STATUS: status_nxt = (status_o & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        CP0_REG_CAUSE:  cause_nxt  = (cause_nxt & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
        CP0_REG_EPC:    epc_nxt    = wdata_i;
        default: ;
      endcase
    end

    if (is_exception(excepttype_i)) begin
      // Nested exceptions keep the original return address and BD flag
      if (!status_o[STATUS_EXL_BIT]) begin
        epc_nxt                = is_in_delayslot_i ? (pc_i - XLEN'(4)) : pc_i;
        cause_nxt[CAUSE_BD_BIT] = is_in_delayslot_i;
      end
      status_nxt[STATUS_EXL_BIT]               = 1'b1;
      cause_nxt[CAUSE_EXC_MSB:CAUSE_EXC_LSB]   = exc_code(excepttype_i);
      if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) begin
        badvaddr_nxt = bad_addr_i;
      end
    end else if (excepttype_i == EXC_ERET) begin
      status_nxt[STATUS_EXL_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_o   <= STATUS_RESET;
      cause_o    <= '0;
      epc_o      <= '0;
      badvaddr_o <= '0;
    end else begin
      status_o   <= status_nxt;
      cause_o    <= cause_nxt;
      epc_o      <= epc_nxt;
      badvaddr_o <= badvaddr_nxt;
    end
  end

  // MFC0 read mux; same-cycle writes are not forwarded
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_REG_BADVADDR: rdata_o = badvaddr_o;
      CP0_REG_COUNT:    rdata_o = count_o;
      CP0_REG_COMPARE:  rdata_o = compare_o;
      CP0_REG_STATUS:   rdata_o = status_o;
      CP0_REG_CAUSE:    rdata_o = cause_o;
      CP0_REG_EPC:      rdata_o = epc_o;
      CP0_REG_PRID:     rdata_o = PRID_VALUE;
      CP0_REG_CONFIG:   rdata_o = CONFIG_VALUE;
      default:          rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios with literal
// expectations, then randomized traffic against a field-level model.
module tb_cp0_regfile;

  logic        clk;
  logic        resetn;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o;

  int n_vec  = 0;
  int n_fail = 0;

  cp0_regfile dut (
    .clk               (clk),
    .resetn            (resetn),
    .we_i              (we_i),
    .waddr_i           (waddr_i),
    .wdata_i           (wdata_i),
    .raddr_i           (raddr_i),
    .rdata_o           (rdata_o),
    .int_i             (int_i),
    .excepttype_i      (excepttype_i),
    .pc_i              (pc_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .bad_addr_i        (bad_addr_i),
    .count_o           (count_o),
    .compare_o         (compare_o),
    .status_o          (status_o),
    .cause_o           (cause_o),
    .epc_o             (epc_o),
    .badvaddr_o        (badvaddr_o),
    .timer_int_o       (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (field level) ----------------
  bit          m_tick;
  logic [31:0] m_count, m_compare;
  bit          m_tint;
  bit          m_exl, m_ie, m_bd;
  logic [7:0]  m_im;
  logic [4:0]  m_exc;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_iphw;
  logic [31:0] m_epc, m_bva;
  // values from before the clock edge
  logic [31:0] o_count, o_compare;
  bit          o_tint, o_exl, o_tick;

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) + (32'(m_iphw) << 10) + (32'(m_ipsw) << 8) + (32'(m_exc) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      5'd16:   return 32'h8000_0000;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tick = 0; m_count = 0; m_compare = 0; m_tint = 0;
      m_exl = 0; m_ie = 0; m_bd = 0; m_im = 0; m_exc = 0;
      m_ipsw = 0; m_iphw = 0; m_epc = 0; m_bva = 0;
    end else begin
      o_count = m_count; o_compare = m_compare; o_tint = m_tint;
      o_exl = m_exl; o_tick = m_tick;
      m_tick = !o_tick;
      if (we_i && waddr_i == 5'd9) m_count = wdata_i;
      else if (o_tick) m_count = o_count + 32'd1;
      if (we_i && waddr_i == 5'd11) begin
        m_compare = wdata_i;
        m_tint = 0;
      end else if (o_count == o_compare && o_compare != 0) begin
        m_tint = 1;
      end
      m_iphw = {int_i[5] | o_tint, int_i[4:0]};
      if (we_i && waddr_i == 5'd12) begin
        m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0];
      end
      if (we_i && waddr_i == 5'd13) m_ipsw = wdata_i[9:8];
      if (we_i && waddr_i == 5'd14) m_epc = wdata_i;
      case (excepttype_i)
        32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc: begin
          if (!o_exl) begin
            m_epc = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
            m_bd  = is_in_delayslot_i;
          end
          m_exl = 1;
          m_exc = (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];
          if (excepttype_i == 32'h4 || excepttype_i == 32'h5) m_bva = bad_addr_i;
        end
        32'he: m_exl = 0;
        default: ;
      endcase
    end
  end

  // Compare process: every cycle out of reset, all outputs vs model
  always @(negedge clk) begin
    if (resetn) begin
      chk("count",     count_o,             m_count);
      chk("compare",   compare_o,           m_compare);
      chk("status",    status_o,            m_status());
      chk("cause",     cause_o,             m_cause());
      chk("epc",       epc_o,               m_epc);
      chk("badvaddr",  badvaddr_o,          m_bva);
      chk("timer_int", 32'(timer_int_o),    32'(m_tint));
      chk("rdata",     rdata_o,             m_read(raddr_i));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we_i = 0; waddr_i = 0; wdata_i = 0; int_i = 0;
    excepttype_i = 0; pc_i = 0; is_in_delayslot_i = 0; bad_addr_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1; waddr_i = a; wdata_i = d;
    cyc();
    we_i = 0;
  endtask

  task automatic except(input logic [31:0] t, input logic [31:0] pc,
                        input logic ds, input logic [31:0] ba);
    excepttype_i = t; pc_i = pc; is_in_delayslot_i = ds; bad_addr_i = ba;
    cyc();
    excepttype_i = 0;
  endtask

  logic [31:0] exc_list [11];
  logic [4:0]  reg_list [8];
  bit          seen;

  initial begin
    exc_list = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he,
                 32'h3, 32'hd, 32'hdead};
    reg_list = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    idle();
    raddr_i = 5'd12;
    resetn  = 0;
    repeat (2) @(posedge clk);
    #2 resetn = 1;

    // Reset values and constant reads
    #1;
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_rd12",   rdata_o,  32'h0040_0000);
    raddr_i = 5'd15; #1;
    chk("rd_prid",    rdata_o,  32'h0000_4220);
    raddr_i = 5'd16; #1;
    chk("rd_config",  rdata_o,  32'h8000_0000);
    chk("rst_count",  count_o,  32'h0);
    repeat (4) cyc();
    chk("count_rate", count_o,  32'd2);

    // Timer: Compare=5, wait for the match
    mtc0(5'd11, 32'd5);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (timer_int_o) seen = 1;
      else cyc();
    end
    chk("timer_set_seen", 32'(seen), 32'd1);
    chk("timer_set_count", count_o, 32'd5);
    cyc();
    chk("cause_ip7", 32'(cause_o[15]), 32'd1);
    mtc0(5'd11, 32'd0);
    chk("timer_clr", 32'(timer_int_o), 32'd0);
    // Count wraps through 0 while Compare==0: no interrupt
    mtc0(5'd9, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("timer_cmp0", 32'(timer_int_o), 32'd0);
    end

    // Syscall in delay slot
    except(32'h8, 32'hbfc0_0104, 1'b1, 32'h0);
    chk("sys_epc",  epc_o,               32'hbfc0_0100);
    chk("sys_bd",   32'(cause_o[31]),    32'd1);
    chk("sys_exc",  32'(cause_o[6:2]),   32'h8);
    chk("sys_exl",  32'(status_o[1]),    32'd1);

    // Nested Ov with EXL=1, then ERET
    except(32'hc, 32'h8000_0010, 1'b0, 32'h0);
    chk("nest_epc", epc_o,               32'hbfc0_0100);
    chk("nest_exc", 32'(cause_o[6:2]),   32'hc);
    except(32'he, 32'h0, 1'b0, 32'h0);
    chk("eret_exl", 32'(status_o[1]),    32'd0);

    // AdES
    except(32'h5, 32'h0000_0400, 1'b0, 32'h0000_0003);
    chk("ades_bva", badvaddr_o,          32'h0000_0003);
    chk("ades_exc", 32'(cause_o[6:2]),   32'h5);
    except(32'he, 32'h0, 1'b0, 32'h0);

    // Write masks
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", status_o, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("cause_mask",  cause_o,  32'h0000_0314);
    mtc0(5'd8, 32'hFFFF_FFFF);
    chk("bva_ro",      badvaddr_o, 32'h0000_0003);
    mtc0(5'd12, 32'h0);

    // Same-cycle MTC0 EPC and interrupt exception: exception wins
    we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1234;
    except(32'h1, 32'h200, 1'b0, 32'h0);
    we_i = 0;
    chk("coll_epc", epc_o,             32'h0000_0200);
    chk("coll_exc", 32'(cause_o[6:2]), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      we_i = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 8);
      waddr_i = (r == 8) ? 5'($urandom_range(0, 31)) : reg_list[r];
      wdata_i = $urandom;
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
        wdata_i = m_count + 32'($urandom_range(0, 6));
      if (waddr_i == 5'd9 && $urandom_range(0, 3) == 0)
        wdata_i = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      raddr_i = ($urandom_range(0, 1) == 1) ? reg_list[$urandom_range(0, 7)]
                                            : 5'($urandom_range(0, 31));
      int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'h0;
      if ($urandom_range(0, 9) < 7) excepttype_i = 0;
      else excepttype_i = exc_list[$urandom_range(0, 10)];
      pc_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      is_in_delayslot_i = 1'($urandom_range(0, 1));
      bad_addr_i = $urandom;
      cyc();
      if (n == 1500) begin
        // Asynchronous reset mid-run
        idle();
        resetn = 0;
        #1;
        chk("areset_status", status_o, 32'h0040_0000);
        chk("areset_count",  count_o,  32'h0);
        chk("areset_epc",    epc_o,    32'h0);
        cyc();
        resetn = 1;
      end
    end
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
